// File: rtl/alu_cmd_driver.sv
// Request FIFO plus a four-state issue sequencer for the registered 32-bit ALU.
// Optional statistics outputs (op_count, fifo_level) are built when ALU_CMD_DRIVER_STATS_EN is defined.
module alu_cmd_driver #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [WIDTH-1:0]              req_a,
   input  logic [WIDTH-1:0]              req_b,
   input  logic [1:0]                    req_op,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [WIDTH-1:0]              rsp_data,
   output logic [WIDTH-1:0]              alu_a,
   output logic [WIDTH-1:0]              alu_b,
   output logic [1:0]                    alu_op,
   output logic                          alu_en,
   input  logic [WIDTH-1:0]              alu_result
`ifdef ALU_CMD_DRIVER_STATS_EN
   ,
   output logic [31:0]                   op_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   req_t             mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   state_t           state_q;
   logic             rsp_valid_q, alu_en_q;
   logic [WIDTH-1:0] rsp_data_q, alu_a_q, alu_b_q;
   logic [1:0]       alu_op_q;
   logic             push, pop, empty;
   req_t             head;

   assign req_ready = (count_q != CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign push      = req_valid && req_ready;
   assign pop       = (state_q == ISSUE);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{a: req_a, b: req_b, op: req_op};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         alu_en_q    <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
      end else begin
         alu_en_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!empty) begin
                  alu_a_q  <= head.a;
                  alu_b_q  <= head.b;
                  alu_op_q <= head.op;
                  alu_en_q <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: state_q <= WAIT;
            // alu_result is only trusted here, one cycle after the enable pulse.
            WAIT: begin
               rsp_data_q  <= alu_result;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  if (!empty) begin
                     alu_a_q  <= head.a;
                     alu_b_q  <= head.b;
                     alu_op_q <= head.op;
                     alu_en_q <= 1'b1;
                     state_q  <= ISSUE;
                  end else begin
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign alu_en    = alu_en_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;

`ifdef ALU_CMD_DRIVER_STATS_EN
   logic [31:0] op_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        op_count_q <= '0;
      else if (rsp_valid_q && rsp_ready) op_count_q <= op_count_q + 32'd1;
   end

   assign op_count   = op_count_q;
   assign fifo_level = count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural registered ALU and an in-order scoreboard.
module tb_alu_cmd_driver;

   localparam int W = 32;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready;
   logic [W-1:0]  req_a, req_b;
   logic [1:0]    req_op;
   logic          rsp_valid, rsp_ready;
   logic [W-1:0]  rsp_data;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [1:0]    alu_op;
   logic          alu_en;
`ifdef ALU_CMD_DRIVER_STATS_EN
   logic [31:0]            op_count;
   logic [$clog2(D):0]     fifo_level;
`endif

   alu_cmd_driver #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
      .alu_result(alu_result)
`ifdef ALU_CMD_DRIVER_STATS_EN
      , .op_count(op_count), .fifo_level(fifo_level)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // Registered ALU with no reset, as the real one.
   always @(posedge clk) if (alu_en) alu_result <= alu_ref(alu_a, alu_b, alu_op);

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int en_cnt = 0;
   int hs_total = 0;
   int rise_cyc = 0;
   logic [W-1:0] sb[$];
   int hs_cyc[$];
   logic rv_prev = 1'b0, rr_prev = 1'b0;
   logic [W-1:0] rd_prev = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: checks data on each handshake and holding under backpressure.
   always @(negedge clk) begin
      if (rst_n) begin
         if (alu_en) en_cnt++;
         if (rsp_valid && !rv_prev) rise_cyc = cyc;
         if (rv_prev && !rr_prev) begin
            chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data_hold", rsp_data, rd_prev);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL spurious_rsp: observed %h expected no response", rsp_data);
            end else begin
               chk("rsp_data", rsp_data, sb.pop_front());
            end
            hs_cyc.push_back(cyc);
            hs_total++;
         end
      end
      rv_prev = rst_n && rsp_valid;
      rr_prev = rsp_ready;
      rd_prev = rsp_data;
   end

   // Drive one request; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic [W-1:0] exp);
      logic ok = 1'b0;
      req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk); ok = req_ready;
         @(posedge clk); #1;
      end
      if (ok) sb.push_back(exp);
      else chk("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk(tag, sb.size(), 32'd0);
   endtask

   initial begin
      int acc_cyc, accepted, spur;
      logic r;
      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;

      // single add: latency and one-cycle enable
      en_cnt = 0;
      send(32'd5, 32'd3, 2'd0, 32'd8);
      acc_cyc = cyc;
      drain("add_drain");
      chk("add_latency", rise_cyc - acc_cyc, 32'd3);
      chk("add_en_pulses", en_cnt, 32'd1);

      // wrap-around cases
      send(32'd0, 32'd1, 2'd1, 32'hFFFF_FFFF);
      send(32'h8000_0000, 32'h8000_0000, 2'd0, 32'd0);
      drain("wrap_drain");

      // back-to-back in order, 3 cycles apart
      hs_cyc.delete();
      send(32'hF0F0, 32'h0FF0, 2'd2, 32'h00F0);
      send(32'hF000, 32'h000F, 2'd3, 32'hF00F);
      send(32'd10, 32'd4, 2'd1, 32'd6);
      drain("b2b_drain");
      chk("b2b_count", hs_cyc.size(), 32'd3);
      chk("b2b_gap0", hs_cyc[1] - hs_cyc[0], 32'd3);
      chk("b2b_gap1", hs_cyc[2] - hs_cyc[1], 32'd3);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("op_count_6", op_count, 32'd6);
`endif

      // backpressure: FIFO_DEPTH queued plus one in flight
      rsp_ready = 1'b0;
      accepted = 0;
      req_valid = 1'b1;
      req_a = 32'h1000_0007; req_b = 32'd1; req_op = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); r = req_ready;
         @(posedge clk); #1;
         if (r) begin
            sb.push_back(alu_ref(req_a, req_b, req_op));
            accepted++;
            req_a = req_a + 32'h1000_0000; req_b = req_b + 32'd3; req_op = req_op + 2'd1;
         end
      end
      req_valid = 1'b0;
      chk("bp_accepted", accepted, 32'd5);
      @(negedge clk);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("bp_fifo_level", {29'd0, fifo_level}, 32'd4);
`endif
      @(posedge clk); #1 rsp_ready = 1'b1;
      drain("bp_drain");
      chk("bp_total", hs_total, 32'd11);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("op_count_11", op_count, 32'd11);
      chk("fifo_level_0", {29'd0, fifo_level}, 32'd0);
`endif

      // reset while in WAIT with two requests queued
      send(32'd1, 32'd2, 2'd0, 32'd3);
      send(32'd4, 32'd5, 2'd0, 32'd9);
      send(32'd6, 32'd7, 2'd0, 32'd13);
      rst_n = 1'b0;
      sb.delete();
      hs_total = 0;
      #1;
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_alu_en", {31'd0, alu_en}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      spur = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid || alu_en) spur++;
      end
      chk("mid_rst_no_rsp", spur, 32'd0);

      // recovery after reset
      @(posedge clk); #1;
      send(32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
      drain("post_rst_drain");
      chk("post_rst_total", hs_total, 32'd1);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("op_count_post_rst", op_count, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator-side sequencer for the team's 32-bit registered ALU (ops: 0=add, 1=sub, 2=and, 3=or; one-cycle latency when enabled).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each request to the ALU as a single-cycle enable pulse, captures the registered result, and returns it in order over a valid/ready response interface.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO not full.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  2  ALU op code.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  captured ALU result.
- alu_a  out  WIDTH  to ALU input_a.
- alu_b  out  WIDTH  to ALU input_b.
- alu_op  out  2  to ALU op.
- alu_en  out  1  to ALU en.
- alu_result  in  WIDTH  from ALU result.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and count cleared; FSM to IDLE.
  - req_ready=1 once released; rsp_valid=0; rsp_data=0; alu_en=0; alu_a/alu_b/alu_op=0.
  - The ALU has no reset, so alu_result is never sampled except in WAIT.
- FIFO:
  - Push on req_valid && req_ready; req_ready = !full. It is purely a count check.
  - A push is refused when full, even in a cycle where a pop also occurs.
  - Pop happens on the ISSUE->WAIT transition.
  - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE: alu_en=0. Go to ISSUE if the FIFO is non-empty, else stay. No same-cycle bypass: a push into an empty FIFO is seen the next cycle.
  - ISSUE: alu_a/alu_b/alu_op driven from the FIFO head, registered on the IDLE/RESP->ISSUE edge. alu_en=1 for exactly this one cycle. Pop the head; go to WAIT.
  - WAIT: alu_en=0; alu_a/b/op hold. alu_result holds the new value. At the end of WAIT, rsp_data <= alu_result and rsp_valid <= 1; go to RESP.
  - RESP: rsp_valid=1; rsp_data stable until handshake.
    - On rsp_ready: rsp_valid <= 0; go to ISSUE if the FIFO is non-empty, else IDLE.
    - If rsp_ready=0: hold indefinitely.
- Latency and throughput:
  - Request accepted at edge 0 -> rsp_valid high after edge 3 (empty FIFO, idle FSM).
  - Maximum throughput is one op per 3 cycles with rsp_ready held high.
- Ordering: responses are strictly in request order.
- No arithmetic is performed here. Wrap/overflow semantics are the ALU's (modulo 2^WIDTH).
- Reset during ISSUE/WAIT/RESP: the in-flight op and all queued ops are discarded; no response is produced.
- Buffering: up to FIFO_DEPTH+1 requests may be accepted while rsp_ready=0 (FIFO_DEPTH queued plus one in flight).

Optional Feature:
- Macro: ALU_CMD_DRIVER_STATS_EN.
- Defined:
  - Adds output op_count [31:0], reset 0.
  - Increments by 1 on each rsp_valid && rsp_ready and wraps 0xFFFFFFFF -> 0.
  - Adds output fifo_level [log2(FIFO_DEPTH):0] equal to the current FIFO count.
- Not defined: neither port exists; no counter logic.

Test Plan:
- Single add: a=5, b=3, op=0 accepted at edge 0, rsp_ready=1 -> rsp_valid after edge 3, rsp_data=8, alu_en high exactly one cycle.
- Sub wrap: a=0, b=1, op=1 -> rsp_data=0xFFFFFFFF; then a=0x80000000, b=0x80000000, op=0 -> rsp_data=0.
- Back-to-back in order: push and (0xF0F0,0x0FF0,2), or (0xF000,0x000F,3), sub (10,4,1) with rsp_ready=1 -> responses 0x00F0, 0xF00F, 6 in that order, 3 cycles apart.
- Backpressure: rsp_ready=0, req_valid=1 continuously with FIFO_DEPTH=4:
  - exactly 5 requests accepted, then req_ready=0;
  - rsp_valid held with stable rsp_data;
  - after rsp_ready=1, all 5 responses return in order.
- Reset mid-op: assert rst_n=0 while in WAIT with 2 requests queued -> rsp_valid=0, alu_en=0 immediately; after release req_ready=1 and no response appears within 10 cycles.
- With ALU_CMD_DRIVER_STATS_EN defined: complete 3 ops -> op_count=3. fifo_level tracks pushes/pops during the backpressure scenario (reaches 4).
